// File: rtl/vram_pkg.sv
// Shared constants, FSM state type and pixel-select helper for the VRAM writer.
package vram_pkg;

   localparam int ADDR_W       = 15;
   localparam int PIX_W        = 2;
   localparam int PIX_PER_BYTE = 4;
   localparam int FRAME_PIX    = 32768;

   typedef enum logic {
      IDLE,
      UNPACK
   } state_t;

   // Pixel 0 is the MSB pair of the packed byte.
   function automatic logic [PIX_W-1:0] pix_sel(input logic [7:0] b, input logic [1:0] idx);
      logic [PIX_W-1:0] r;
      case (idx)
         2'd0:    r = b[7:6];
         2'd1:    r = b[5:4];
         2'd2:    r = b[3:2];
         default: r = b[1:0];
      endcase
      return r;
   endfunction

endpackage

// File: rtl/vram_addr_ctr.sv
// Framebuffer write-address counter: steps once per write, wraps at the end of
// the frame with a one-cycle done pulse, and is zeroed by restart.
module vram_addr_ctr #(
   parameter int ADDR_W    = vram_pkg::ADDR_W,
   parameter int FRAME_PIX = vram_pkg::FRAME_PIX
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              restart,
   input  logic              step,
   output logic [ADDR_W-1:0] addr,
   output logic              frame_done
);
   import vram_pkg::*;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_PIX - 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr       <= '0;
         frame_done <= 1'b0;
      end else begin
         // Restart wins: the address is re-zeroed and no done pulse escapes.
         frame_done <= step && (addr == LAST) && !restart;
         if (restart)
            addr <= '0;
         else if (step)
            addr <= (addr == LAST) ? '0 : addr + 1'b1;
      end
   end

endmodule

// File: rtl/vram_writer.sv
// Unpacks bytes of four 2-bit pixels into sequential framebuffer writes,
// one pixel per cycle, with all outputs registered.
module vram_writer #(
   parameter int ADDR_W    = vram_pkg::ADDR_W,
   parameter int FRAME_PIX = vram_pkg::FRAME_PIX
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_restart,
   input  logic [7:0]        i_data,
   input  logic              i_valid,
   output logic              o_ready,
   output logic              o_we,
   output logic [ADDR_W-1:0] o_addr,
   output logic [1:0]        o_wdata,
   output logic              o_frame_done,
   output logic              o_busy
);
   import vram_pkg::*;

   localparam logic [1:0] LAST_PIX = 2'(PIX_PER_BYTE - 1);

   state_t     state;
   logic [1:0] pix;
   logic [7:0] data_q;
   logic       accept;

   assign accept = i_valid & o_ready;

   // The counter register itself is the address port; it steps on each edge
   // that closes a write cycle.
   vram_addr_ctr #(
      .ADDR_W    (ADDR_W),
      .FRAME_PIX (FRAME_PIX)
   ) u_ctr (
      .clk        (i_clk),
      .rst_n      (i_rst_n),
      .restart    (i_restart),
      .step       (o_we),
      .addr       (o_addr),
      .frame_done (o_frame_done)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state   <= IDLE;
         pix     <= '0;
         data_q  <= '0;
         o_we    <= 1'b0;
         o_wdata <= '0;
         o_busy  <= 1'b0;
         o_ready <= 1'b0;
      end else if (accept) begin
         // o_ready is only high in IDLE or on the last pixel, so this also
         // covers back-to-back bytes and restart-with-accept.
         state   <= UNPACK;
         pix     <= '0;
         data_q  <= i_data;
         o_we    <= 1'b1;
         o_wdata <= pix_sel(i_data, 2'd0);
         o_busy  <= 1'b1;
         o_ready <= 1'b0;
      end else if (i_restart || state == IDLE || pix == LAST_PIX) begin
         state   <= IDLE;
         pix     <= '0;
         o_we    <= 1'b0;
         o_busy  <= 1'b0;
         o_ready <= 1'b1;
      end else begin
         pix     <= pix + 2'd1;
         o_wdata <= pix_sel(data_q, pix + 2'd1);
         o_ready <= (pix + 2'd1 == LAST_PIX);
      end
   end

endmodule

// File: tb/tb_vram_writer.sv
// Directed bench for vram_writer: a pixel-queue model checked every cycle, plus
// literal expectations for latency, restart, reset and frame wrap.
module tb_vram_writer;

   localparam int AW = 15;
   localparam int FP = 32768;

   logic          i_clk = 1'b0;
   logic          i_rst_n;
   logic          i_restart = 1'b0;
   logic [7:0]    i_data = 8'h00;
   logic          i_valid = 1'b0;
   logic          o_ready, o_we, o_frame_done, o_busy;
   logic [AW-1:0] o_addr;
   logic [1:0]    o_wdata;

   int tests = 0;
   int fails = 0;

   vram_writer #(.ADDR_W(AW), .FRAME_PIX(FP)) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_restart    (i_restart),
      .i_data       (i_data),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .o_we         (o_we),
      .o_addr       (o_addr),
      .o_wdata      (o_wdata),
      .o_frame_done (o_frame_done),
      .o_busy       (o_busy)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         if (fails <= 40) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Model: queue of pixels still to be written; head is this cycle's write.
   int q[$];
   int m_addr  = 0;
   bit m_done  = 1'b0;
   bit m_ready = 1'b0;

   always @(posedge i_clk or negedge i_rst_n) begin : model
      bit acc, wr;
      if (!i_rst_n) begin
         q.delete();
         m_addr  = 0;
         m_done  = 1'b0;
         m_ready = 1'b0;
      end else begin
         acc    = i_valid && m_ready;
         wr     = q.size() > 0;
         m_done = wr && (m_addr == FP - 1) && !i_restart;
         if (i_restart)  m_addr = 0;
         else if (wr)    m_addr = (m_addr + 1) % FP;
         if (acc) begin
            q.delete();
            for (int i = 0; i < 4; i++) q.push_back((int'(i_data) >> (6 - 2*i)) & 3);
         end else if (i_restart) begin
            q.delete();
         end else if (wr) begin
            void'(q.pop_front());
         end
         m_ready = q.size() <= 1;
      end
   end

   int we_cnt = 0, fd_cnt = 0, prev_addr = -1, fd_prev = -1, fd_cur = -1;

   always @(negedge i_clk) begin : compare
      chk("we",         int'(o_we),         int'(q.size() > 0));
      chk("busy",       int'(o_busy),       int'(q.size() > 0));
      chk("ready",      int'(o_ready),      int'(m_ready));
      chk("frame_done", int'(o_frame_done), int'(m_done));
      if (q.size() > 0) begin
         chk("addr",  int'(o_addr),  m_addr);
         chk("wdata", int'(o_wdata), q[0]);
      end
      if (o_frame_done) begin
         fd_cnt++;
         fd_prev = prev_addr;
         fd_cur  = o_we ? int'(o_addr) : -1;
      end
      if (o_we) begin
         we_cnt++;
         prev_addr = int'(o_addr);
      end else begin
         prev_addr = -1;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge i_clk);
      #2;
   endtask

   // Returns 2 ns after the accepting edge.
   task automatic send(input logic [7:0] b);
      int n = 0;
      i_valid = 1'b1;
      i_data  = b;
      @(negedge i_clk);
      while (!o_ready && n < 20) begin
         @(negedge i_clk);
         n++;
      end
      if (!o_ready) chk("handshake_timeout", int'(o_ready), 1);
      @(posedge i_clk);
      #2;
      i_valid = 1'b0;
   endtask

   task automatic pulse_restart();
      i_restart = 1'b1;
      tick(1);
      i_restart = 1'b0;
   endtask

   initial begin
      int c0, f0;
      i_rst_n = 1'b1;
      #1 i_rst_n = 1'b0;

      // Reset state
      repeat (3) @(negedge i_clk);
      chk("rst_ready", int'(o_ready), 0);
      chk("rst_we",    int'(o_we),    0);
      chk("rst_addr",  int'(o_addr),  0);
      chk("rst_wdata", int'(o_wdata), 0);
      chk("rst_fd",    int'(o_frame_done), 0);
      chk("rst_busy",  int'(o_busy),  0);
      @(posedge i_clk); #2 i_rst_n = 1'b1;
      @(negedge i_clk) chk("ready_pre_edge", int'(o_ready), 0);
      @(negedge i_clk) chk("ready_post_edge", int'(o_ready), 1);
      tick(1);

      // Single byte 0xE4: writes 3,2,1,0 at addr 0..3
      send(8'hE4);
      for (int i = 0; i < 4; i++) begin
         @(negedge i_clk);
         chk("e4_we",    int'(o_we),    1);
         chk("e4_addr",  int'(o_addr),  i);
         chk("e4_wdata", int'(o_wdata), 3 - i);
         chk("e4_ready", int'(o_ready), (i == 3) ? 1 : 0);
      end
      tick(3);

      // Gap-free stream of 8 bytes from addr 0
      pulse_restart();
      c0 = we_cnt;
      for (int i = 0; i < 8; i++) send(8'(8'h1B + 8'(i * 29)));
      tick(6);
      chk("stream_we_count", we_cnt - c0, 32);

      // Valid held high with data changing every cycle
      i_valid = 1'b1;
      for (int i = 0; i < 14; i++) begin
         i_data = 8'(i * 37 + 5);
         tick(1);
      end
      i_valid = 1'b0;
      tick(6);

      // Restart during pix==1 of the byte at addr 100
      pulse_restart();
      for (int i = 0; i < 25; i++) send(8'(i));
      send(8'hFF);
      tick(1);
      i_restart = 1'b1;
      @(negedge i_clk);
      chk("rs_pix1_addr", int'(o_addr), 101);
      chk("rs_pix1_we",   int'(o_we),   1);
      tick(1);
      i_restart = 1'b0;
      @(negedge i_clk);
      chk("rs_we_low", int'(o_we), 0);
      chk("rs_no_fd",  int'(o_frame_done), 0);
      tick(1);
      send(8'h9C);
      @(negedge i_clk);
      chk("rs_next_addr",  int'(o_addr),  0);
      chk("rs_next_wdata", int'(o_wdata), 2);
      tick(5);

      // Async reset mid-UNPACK
      send(8'h5A);
      @(negedge i_clk);
      #1 i_rst_n = 1'b0;
      #1;
      chk("arst_we",    int'(o_we),    0);
      chk("arst_ready", int'(o_ready), 0);
      chk("arst_busy",  int'(o_busy),  0);
      @(posedge i_clk); #2 i_rst_n = 1'b1;
      @(negedge i_clk) chk("arst_ready_pre", int'(o_ready), 0);
      @(negedge i_clk) chk("arst_ready_post", int'(o_ready), 1);
      tick(1);
      send(8'hC3);
      @(negedge i_clk);
      chk("arst_addr0",  int'(o_addr),  0);
      chk("arst_wdata0", int'(o_wdata), 3);
      tick(5);

      // Full frame plus one byte: wrap and single done pulse
      pulse_restart();
      f0 = fd_cnt;
      for (int i = 0; i < FP / 4 + 1; i++) send(8'(i * 7 + 3));
      tick(8);
      chk("frame_done_count", fd_cnt - f0, 1);
      chk("frame_last_addr",  fd_prev, FP - 1);
      chk("frame_wrap_addr",  fd_cur, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/vram_writer.md
VRAM_WRITER -- requirements
Module: vram_writer

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, framebuffer write-address width (256x128 pixels at 2 bits).
REQ-002 SHALL have parameter FRAME_PIX, default 32768, pixels per frame; the last address is FRAME_PIX-1.
REQ-003 SHALL have port i_clk, input, 1: single clock, LCD_CLK domain; every flop is clocked on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port i_restart, input, 1: synchronous pulse that returns the write address to 0.
REQ-006 SHALL have port i_data, input, 8: packed byte of 4 pixels of 2 bits each, MSB pixel first.
REQ-007 SHALL have port i_valid, input, 1: i_data is valid.
REQ-008 SHALL have port o_ready, output, 1: the block accepts i_data this cycle.
REQ-009 SHALL have port o_we, output, 1: framebuffer write enable.
REQ-010 SHALL have port o_addr, output, ADDR_W: framebuffer write address, laid out as {y[6:0], x[7:0]}.
REQ-011 SHALL have port o_wdata, output, 2: pixel colour index.
REQ-012 SHALL have port o_frame_done, output, 1: one-cycle pulse after the last pixel of a frame is written.
REQ-013 SHALL have port o_busy, output, 1: high while unpacking a byte.

Function
REQ-014 SHALL implement a 2-state machine: IDLE and UNPACK, with a 2-bit pixel index (pix) and an ADDR_W-bit address counter (addr).
REQ-015 SHALL treat a byte as accepted on the rising edge at which i_valid and o_ready are both 1.
REQ-016 SHALL drive o_ready to 1 in IDLE, and in UNPACK only when pix==3; o_ready SHALL be 0 otherwise.
REQ-017 SHALL latch i_data on acceptance, then enter UNPACK with pix=0.
REQ-018 SHALL make o_busy equal to (state==UNPACK).
REQ-019 SHALL set o_we=1 on every UNPACK cycle and o_we=0 in IDLE.
REQ-020 SHALL set o_addr=addr on every UNPACK cycle.
REQ-021 SHALL drive o_wdata = byte[7:6], [5:4], [3:2], [1:0] for pix = 0, 1, 2, 3 respectively.
REQ-022 SHALL meet these timing rules:
- latency: byte accepted at edge k gives its first write in cycle k+1;
- sustained throughput: 1 byte per 4 cycles (back-to-back acceptance when pix==3);
- a gap-free stream gives continuous o_we.
REQ-023 SHALL increment addr after each write.
REQ-024 SHALL wrap addr from FRAME_PIX-1 to 0 and pulse o_frame_done for exactly the cycle after that write.
REQ-025 SHALL handle UNPACK exit as follows:
- pix==3 with no acceptance: return to IDLE;
- pix==3 with acceptance: stay in UNPACK with pix=0 and the new byte.
REQ-026 SHALL give i_restart priority over counting:
- addr <- 0;
- any in-progress UNPACK aborts to IDLE, and the remaining pixels of that byte are discarded;
- no o_frame_done pulse is generated.
REQ-027 SHALL, when i_restart coincides with an acceptance, accept the byte and write it starting at addr 0.
REQ-028 SHALL ignore i_data while o_ready=0; no write is produced for a byte that was not accepted.
REQ-029 SHALL drive all outputs from registers only, with no combinational path from any input to any output.

Reset
REQ-030 SHALL, while i_rst_n=0, hold: state=IDLE, pix=0, addr=0, o_we=0, o_addr=0, o_wdata=0, o_frame_done=0, o_busy=0, o_ready=0.
REQ-031 SHALL raise o_ready at the first rising i_clk edge after i_rst_n deasserts.
REQ-032 SHALL, if reset asserts mid-UNPACK, clear all outputs immediately (asynchronously); the partial byte is lost and no further write occurs.

Structure
REQ-033 SHALL keep the following in shared package vram_pkg:
- constants ADDR_W, PIX_W=2, PIX_PER_BYTE=4, FRAME_PIX;
- the state enum (IDLE, UNPACK).
REQ-034 SHALL place the address counter (wrap, restart, frame_done) in a single sub-module, vram_addr_ctr.
REQ-035 SHALL be sized to fit 120-400 lines of RTL.

Verification
REQ-036 SHALL cover: one byte 0xE4 accepted at edge k -> writes at addr 0..3 with wdata 3,2,1,0 in cycles k+1..k+4; o_ready=0 on the first 3 of those cycles.
REQ-037 SHALL cover: continuous valid stream of 8 bytes -> 32 consecutive o_we cycles, addr 0..31, no gaps.
REQ-038 SHALL cover: 8192 bytes streamed -> last write at addr 32767, o_frame_done high for 1 cycle, next write at addr 0.
REQ-039 SHALL cover: i_restart during pix==1 of a byte at addr 100 -> o_we low next cycle, the next byte writes at addr 0, no o_frame_done.
REQ-040 SHALL cover: i_rst_n pulled low mid-UNPACK -> o_we=0 and o_ready=0 immediately; after release, o_ready=1 one edge later and addr restarts at 0.
REQ-041 SHALL cover: i_valid held high with o_ready=0 and changing i_data -> only the values sampled at acceptance edges are written.
